// File: rtl/pipe_pkg.sv
// Shared pipeline types: register index, hazard FSM states, zero-register constant.
package pipe_pkg;

   typedef logic [4:0] reg_idx_t;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_t;

   localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall-cycle and flush event counters; wrap modulo 2^CNT_W, cleared by synchronous reset.
// Registered, one-cycle update latency; no backpressure.
module hazard_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall,
   input  logic             flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch-flush / memory-freeze hazard controller; Mealy outputs, zero latency.
// Optional perf counters under HAZARD_PERF_EN; memory stall is held until ack or timeout.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  reg_idx_t         ifid_rs_i,
   input  reg_idx_t         ifid_rt_i,
   input  logic             idex_memread_i,
   input  reg_idx_t         idex_rt_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             pc_stall_o,
   output logic             ifid_stall_o,
   output logic             flush_o,
   output logic             bubble_o,
   output logic             freeze_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

   hz_state_t         state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              err_q, err_d;
   logic              lu;

   assign lu = idex_memread_i && (idex_rt_i != REG_ZERO) &&
               ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         wcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      err_d   = err_q;
      case (state_q)
         MEM_WAIT: begin
            if (mem_ack_i) begin
               state_d = RUN;
               wcnt_d  = '0;
            end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT)) begin
               // Give up on the access: the pipeline resumes and the error sticks.
               err_d   = 1'b1;
               state_d = RUN;
               wcnt_d  = '0;
            end else begin
               wcnt_d  = wcnt_q + WCNT_W'(1);
            end
         end
         default: begin
            if (mem_req_i) begin
               state_d = MEM_WAIT;
               wcnt_d  = WCNT_W'(1);
            end
         end
      endcase
   end

   // mem > load-use > branch; a stalled branch is simply re-evaluated next cycle.
   always_comb begin
      pc_stall_o   = 1'b0;
      ifid_stall_o = 1'b0;
      flush_o      = 1'b0;
      bubble_o     = 1'b0;
      freeze_o     = 1'b0;
      if (!rst_i) begin
         case (state_q)
            MEM_WAIT: begin
               pc_stall_o   = 1'b1;
               ifid_stall_o = 1'b1;
               freeze_o     = 1'b1;
            end
            default: begin
               if (mem_req_i) begin
                  pc_stall_o   = 1'b1;
                  ifid_stall_o = 1'b1;
                  freeze_o     = 1'b1;
               end else if (lu) begin
                  pc_stall_o   = 1'b1;
                  ifid_stall_o = 1'b1;
                  bubble_o     = 1'b1;
               end else if (branch_taken_i) begin
                  flush_o      = 1'b1;
               end
            end
         endcase
      end
   end

   assign err_o = err_q && !rst_i;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   hazard_perf_cnt #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .stall     (pc_stall_o),
      .flush     (flush_o),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   assign stall_cnt_o = rst_i ? '0 : stall_cnt;
   assign flush_cnt_o = rst_i ? '0 : flush_cnt;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle sequences,
// and randomized traffic against a cycle-count reference model.
module tb_hazard_ctrl;
   import pipe_pkg::*;

   localparam int TO = 4;
   localparam int CW = 8;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   reg_idx_t      ifid_rs_i = '0, ifid_rt_i = '0, idex_rt_i = '0;
   logic          idex_memread_i = 1'b0, branch_taken_i = 1'b0;
   logic          mem_req_i = 1'b0, mem_ack_i = 1'b0;
   logic          pc_stall_o, ifid_stall_o, flush_o, bubble_o, freeze_o, err_o;
   logic [CW-1:0] stall_cnt_o, flush_cnt_o;

   hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .ifid_rs_i      (ifid_rs_i),
      .ifid_rt_i      (ifid_rt_i),
      .idex_memread_i (idex_memread_i),
      .idex_rt_i      (idex_rt_i),
      .branch_taken_i (branch_taken_i),
      .mem_req_i      (mem_req_i),
      .mem_ack_i      (mem_ack_i),
      .pc_stall_o     (pc_stall_o),
      .ifid_stall_o   (ifid_stall_o),
      .flush_o        (flush_o),
      .bubble_o       (bubble_o),
      .freeze_o       (freeze_o),
      .err_o          (err_o),
      .stall_cnt_o    (stall_cnt_o),
      .flush_cnt_o    (flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Reference model: an access is "busy" for a number of stall cycles counted from req.
   bit m_busy = 0;
   int m_elapsed = 0;
   bit m_err = 0;
   int m_scnt = 0;
   int m_fcnt = 0;
   bit e_stall, e_bub, e_flush, e_freeze;

   typedef struct {
      logic     memread;
      reg_idx_t idex_rt;
      reg_idx_t rs;
      reg_idx_t rt;
      logic     br;
      logic     ack;
      logic     x_stall;
      logic     x_bub;
      logic     x_flush;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic predict();
      bit hz;
      hz = idex_memread_i && idex_rt_i != 0 &&
           (idex_rt_i == ifid_rs_i || idex_rt_i == ifid_rt_i);
      e_stall = 0; e_bub = 0; e_flush = 0; e_freeze = 0;
      if (!rst_i) begin
         if (m_busy || mem_req_i) begin
            e_stall = 1; e_freeze = 1;
         end else if (hz) begin
            e_stall = 1; e_bub = 1;
         end else if (branch_taken_i) begin
            e_flush = 1;
         end
      end
   endtask

   // Sample at the falling edge and compare every output to the model.
   task automatic sample();
      int xs, xf;
      @(negedge clk_i);
      predict();
      chk("model_outs", 32'({pc_stall_o, ifid_stall_o, flush_o, bubble_o, freeze_o, err_o}),
          32'({e_stall, e_stall, e_flush, e_bub, e_freeze, m_err && !rst_i}));
`ifdef HAZARD_PERF_EN
      xs = rst_i ? 0 : m_scnt % (1 << CW);
      xf = rst_i ? 0 : m_fcnt % (1 << CW);
`else
      xs = 0;
      xf = 0;
`endif
      chk("model_stall_cnt", 32'(stall_cnt_o), 32'(xs));
      chk("model_flush_cnt", 32'(flush_cnt_o), 32'(xf));
   endtask

   task automatic advance();
      @(posedge clk_i);
      if (rst_i) begin
         m_busy = 0; m_elapsed = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
      end else begin
         m_scnt += int'(e_stall);
         m_fcnt += int'(e_flush);
         if (m_busy) begin
            m_elapsed++;
            if (mem_ack_i) m_busy = 0;
            else if (m_elapsed == TO + 1) begin
               m_err = 1;
               m_busy = 0;
            end
         end else if (mem_req_i) begin
            m_busy = 1;
            m_elapsed = 1;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      idex_memread_i = 0; idex_rt_i = 0; ifid_rs_i = 0; ifid_rt_i = 0;
      branch_taken_i = 0; mem_req_i = 0; mem_ack_i = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1;
      sample();
      chk("reset_outs", 32'({pc_stall_o, ifid_stall_o, flush_o, bubble_o, freeze_o, err_o}), 32'd0);
      advance();
      rst_i = 0;
   endtask

   initial begin
      vecs[0] = '{1, 5'd8, 5'd8, 5'd3, 0, 0, 1, 1, 0};  // load-use on rs
      vecs[1] = '{1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0};  // r0 never hazards
      vecs[2] = '{0, 5'd8, 5'd8, 5'd8, 1, 0, 0, 0, 1};  // plain taken branch
      vecs[3] = '{1, 5'd9, 5'd2, 5'd9, 1, 0, 1, 1, 0};  // load-use on rt beats branch
      vecs[4] = '{0, 5'd7, 5'd7, 5'd7, 0, 0, 0, 0, 0};  // not a load
      vecs[5] = '{0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0};  // stray ack in RUN
      vecs[6] = '{1, 5'd5, 5'd6, 5'd7, 0, 0, 0, 0, 0};  // load, no match
      vecs[7] = '{1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 1};  // r0 load, branch flushes

      #1;
      do_reset();

      foreach (vecs[i]) begin
         idex_memread_i = vecs[i].memread; idex_rt_i = vecs[i].idex_rt;
         ifid_rs_i = vecs[i].rs; ifid_rt_i = vecs[i].rt;
         branch_taken_i = vecs[i].br; mem_ack_i = vecs[i].ack; mem_req_i = 0;
         sample();
         chk($sformatf("vec%0d", i), 32'({pc_stall_o, ifid_stall_o, bubble_o, flush_o, freeze_o}),
             32'({vecs[i].x_stall, vecs[i].x_stall, vecs[i].x_bub, vecs[i].x_flush, 1'b0}));
         advance();
      end
      idle_inputs();
      sample();
      chk("lu_one_cycle", 32'(pc_stall_o), 32'd0);
      advance();

      // Branch flush counter
      do_reset();
      branch_taken_i = 1;
      sample();
      chk("br_flush", 32'(flush_o), 32'd1);
      advance();
      branch_taken_i = 0;
      sample();
`ifdef HAZARD_PERF_EN
      chk("br_flush_cnt", 32'(flush_cnt_o), 32'd1);
`else
      chk("br_flush_cnt", 32'(flush_cnt_o), 32'd0);
`endif
      advance();

      // Memory access acked three cycles after req: four stall cycles
      do_reset();
      mem_req_i = 1;
      for (int i = 0; i < 4; i++) begin
         mem_ack_i = (i == 3);
         sample();
         chk("mem_stall", 32'({pc_stall_o, ifid_stall_o, freeze_o, bubble_o, flush_o}), 32'b11100);
         advance();
      end
      idle_inputs();
      sample();
      chk("mem_release", 32'({pc_stall_o, freeze_o}), 32'd0);
      chk("mem_no_err", 32'(err_o), 32'd0);
`ifdef HAZARD_PERF_EN
      chk("mem_stall_cnt", 32'(stall_cnt_o), 32'd4);
`endif
      advance();

      // Timeout: no ack, TO+1 stall cycles then sticky error
      do_reset();
      mem_req_i = 1;
      for (int i = 0; i < TO + 1; i++) begin
         sample();
         chk("to_stall", 32'({pc_stall_o, freeze_o}), 32'b11);
         chk("to_err_low", 32'(err_o), 32'd0);
         advance();
      end
      mem_req_i = 0;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("to_err_held", 32'(err_o), 32'd1);
         chk("to_run", 32'(pc_stall_o), 32'd0);
         advance();
      end

      // Reset mid-wait clears error and state
      mem_req_i = 1;
      sample(); advance();
      sample(); advance();
      mem_req_i = 0;
      rst_i = 1;
      sample();
      chk("rst_wait_outs", 32'({pc_stall_o, ifid_stall_o, flush_o, bubble_o, freeze_o, err_o}), 32'd0);
      advance();
      rst_i = 0;
      sample();
      chk("rst_wait_run", 32'({pc_stall_o, freeze_o, err_o}), 32'd0);
      chk("rst_wait_cnt", 32'({stall_cnt_o, flush_cnt_o}), 32'd0);
      advance();

      // mem + load-use + branch together
      mem_req_i = 1; idex_memread_i = 1; idex_rt_i = 8; ifid_rs_i = 8; branch_taken_i = 1;
      sample();
      chk("simul", 32'({freeze_o, bubble_o, flush_o, pc_stall_o}), 32'b1001);
      advance();
      mem_ack_i = 1;
      sample();
      chk("simul_wait", 32'({freeze_o, bubble_o, flush_o}), 32'b100);
      advance();
      idle_inputs();
      sample(); advance();

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rst_i = ($urandom_range(0, 199) == 0);
         idex_memread_i = $urandom_range(0, 1);
         idex_rt_i = 5'($urandom_range(0, 3));
         ifid_rs_i = 5'($urandom_range(0, 3));
         ifid_rt_i = 5'($urandom_range(0, 3));
         branch_taken_i = ($urandom_range(0, 2) == 0);
         if (m_busy) begin
            mem_req_i = 1;
            mem_ack_i = ($urandom_range(0, 4) == 0);
         end else begin
            mem_req_i = ($urandom_range(0, 5) == 0);
            mem_ack_i = ($urandom_range(0, 19) == 0);
         end
         sample();
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
